// File: rtl/regfile_read_port.sv
// Dual-port registered read stage for the 32-entry register array, with a
// valid/ready response handshake and a saturating stall counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data into the read.
module regfile_read_port #(
  parameter int WIDTH   = 32,
  parameter int NREG    = 32,
  parameter int ZERO_R0 = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic [NREG*WIDTH-1:0] Regs,
  input  logic [NREG-1:0]       Wr_En,
  input  logic [WIDTH-1:0]      Wr_D,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [4:0]            Ra,
  input  logic [4:0]            Rb,
  output logic                  Rsp_Valid,
  input  logic                  Rsp_Ready,
  output logic [WIDTH-1:0]      Qa,
  output logic [WIDTH-1:0]      Qb,
  output logic [CNT_W-1:0]      Stall_Cnt,
  input  logic                  Stall_Clr
);

  logic [WIDTH-1:0] reg_arr [NREG];
  logic [WIDTH-1:0] read_a;
  logic [WIDTH-1:0] read_b;
  logic             accept;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_unflatten
      assign reg_arr[gi] = Regs[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifndef REGFILE_BYPASS_EN
  // Write side is only observed when forwarding is built in.
  logic unused_wr;
  assign unused_wr = ^{Wr_En, Wr_D};
`endif

  // Zero-register check is applied last so it overrides forwarding.
  always_comb begin
    read_a = reg_arr[Ra];
`ifdef REGFILE_BYPASS_EN
    if (Wr_En[Ra]) read_a = Wr_D;
`endif
    if (ZERO_R0 != 0 && Ra == 5'd0) read_a = '0;
  end

  always_comb begin
    read_b = reg_arr[Rb];
`ifdef REGFILE_BYPASS_EN
    if (Wr_En[Rb]) read_b = Wr_D;
`endif
    if (ZERO_R0 != 0 && Rb == 5'd0) read_b = '0;
  end

  assign Req_Ready = !Rsp_Valid || Rsp_Ready;
  assign accept    = Req_Valid && Req_Ready;

  // Data is only loaded on accept, so a stalled response stays a snapshot.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Rsp_Valid <= 1'b0;
      Qa        <= '0;
      Qb        <= '0;
    end else if (accept) begin
      Rsp_Valid <= 1'b1;
      Qa        <= read_a;
      Qb        <= read_b;
    end else if (Rsp_Ready) begin
      Rsp_Valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Stall_Cnt <= '0;
    end else if (Stall_Clr) begin
      Stall_Cnt <= '0;
    end else if (Rsp_Valid && !Rsp_Ready && Stall_Cnt != {CNT_W{1'b1}}) begin
      Stall_Cnt <= Stall_Cnt + 1'b1;
    end
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the 32x32 register array: two independent read ports (A, B) against the flattened register outputs.
- Registered 1-cycle read with a valid/ready handshake toward the execute stage.
- Optional same-cycle write-to-read forwarding.
- Saturating stall counter for performance debug.
- Sits between the register array and the ALU operand muxes; consumes the same one-hot write enable and write data that drive the array.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers; address width is 5 bits.
- ZERO_R0, 1, when 1 address 0 always reads 0 regardless of stored contents.
- CNT_W, 16, stall counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Clrn  in  1  asynchronous active-low reset.
- Regs  in  NREG*WIDTH  flattened array outputs; register i at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- Wr_En  in  NREG  one-hot write enable currently applied to the array; all-zero when no write.
- Wr_D  in  WIDTH  write data currently applied to the array.
- Req_Valid  in  1  read request present.
- Req_Ready  out  1  request accepted this cycle when high together with Req_Valid.
- Ra  in  5  port A register address.
- Rb  in  5  port B register address.
- Rsp_Valid  out  1  Qa/Qb hold a valid response.
- Rsp_Ready  in  1  consumer takes the response.
- Qa  out  WIDTH  port A data.
- Qb  out  WIDTH  port B data.
- Stall_Cnt  out  CNT_W  cycles with Rsp_Valid=1 and Rsp_Ready=0; saturating.
- Stall_Clr  in  1  synchronous clear of Stall_Cnt.

Behaviour:
- Reset (Clrn=0, asynchronous): Rsp_Valid=0, Qa=0, Qb=0, Stall_Cnt=0. Req_Ready=1 after reset because it is combinational on Rsp_Valid.
- Req_Ready = !Rsp_Valid || Rsp_Ready. No combinational path from Ra/Rb to Req_Ready.
- Accept = Req_Valid && Req_Ready. On the Accept edge:
  - Qa <= sel(Ra), Qb <= sel(Rb).
  - Rsp_Valid <= 1.
  - Latency: exactly 1 cycle from accept to Rsp_Valid.
- On an edge with Rsp_Valid && Rsp_Ready && !Accept: Rsp_Valid <= 0. Qa/Qb keep their last value.
- Stalled (Rsp_Valid=1, Rsp_Ready=0): Qa/Qb frozen as a snapshot taken at acceptance. Later writes to the same register do NOT update the held response. A stall never drops or duplicates a response.
- Back-to-back: accept in every cycle that Rsp_Ready=1 gives full throughput, one response per cycle.
- sel(addr):
  - If ZERO_R0=1 and addr=0: result is 0.
  - Otherwise, with forwarding (see Optional Feature) and Wr_En[addr]=1: result is Wr_D.
  - Otherwise: result is Regs slice for addr.
- Ra=Rb is legal; both ports return identical data.
- Stall_Cnt:
  - Increments on each edge with Rsp_Valid && !Rsp_Ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Stall_Clr=1 forces 0 and takes priority over increment.
- Reset mid-transaction discards any pending response; no response is emitted after reset release until a new accept.
- Wr_En with more than one bit set is illegal. Behaviour for that case is unspecified; the bench asserts it is one-hot or zero.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding is active. A read accepted in the same cycle as a write to the same address returns Wr_D, i.e. the post-edge value. ZERO_R0 still has priority at address 0.
- Undefined: no forwarding. The same-cycle read returns the pre-write Regs value. Wr_En and Wr_D are unused, and the decoder must insert a bubble for read-after-write.

Test Plan:
- Reset then preload Regs: r5=0x0000_00A5, r9=0xDEAD_BEEF. Req Ra=5, Rb=9, Rsp_Ready=1 -> next cycle Rsp_Valid=1, Qa=0x0000_00A5, Qb=0xDEAD_BEEF.
- Ra=0 with r0 storage=0xFFFF_FFFF and ZERO_R0=1 -> Qa=0. Same stimulus with ZERO_R0=0 -> Qa=0xFFFF_FFFF.
- Request Ra=7 with Wr_En=1<<7, Wr_D=0x1234_5678, old r7=0x1111_1111 -> Qa=0x1234_5678 with REGFILE_BYPASS_EN, 0x1111_1111 without.
- Hold Rsp_Ready=0 for 4 cycles after an accept, writing r5 meanwhile -> Req_Ready=0, Qa stays at the snapshot, Stall_Cnt=4. Then Rsp_Ready=1 -> one response consumed and Req_Ready=1.
- 10 back-to-back requests Ra=1..10 with Rsp_Ready=1 -> 10 consecutive responses in order, no gaps, Stall_Cnt=0.
- CNT_W=4: stall 20 cycles -> Stall_Cnt=15 (saturated). Pulse Stall_Clr -> 0. Assert Clrn=0 while Rsp_Valid=1 -> Rsp_Valid=0, Qa=Qb=0 immediately.
